// File: rtl/painterengine_gpu_color_pkg.sv
// Shared colour encodings and ARGB output packing for the GPU colour path.
package painterengine_gpu_color_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned PIX_W = 32;

  localparam logic IRGB_BGR = 1'b0;
  localparam logic IRGB_RGB = 1'b1;

  localparam logic [1:0] OARGB_ARGB = 2'b00;
  localparam logic [1:0] OARGB_ABGR = 2'b01;
  localparam logic [1:0] OARGB_RGBA = 2'b10;
  localparam logic [1:0] OARGB_BGRA = 2'b11;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Places the four channels into the selected 32-bit output layout.
  function automatic logic [PIX_W-1:0] pack_argb(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] r,
                                                 input logic [CH_W-1:0] g,
                                                 input logic [CH_W-1:0] b,
                                                 input logic [1:0]      mode);
    logic [PIX_W-1:0] res;
    case (mode)
      OARGB_ARGB: res = {a, r, g, b};
      OARGB_ABGR: res = {a, b, g, r};
      OARGB_RGBA: res = {r, g, b, a};
      default:    res = {b, g, r, a};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/painterengine_gpu_argb_swizzle.sv
// Combinational channel reorder into the selected ARGB output layout.
module painterengine_gpu_argb_swizzle
  import painterengine_gpu_color_pkg::*;
(
  input  logic [CH_W-1:0]  a_i,
  input  rgb_t             rgb_i,
  input  logic [1:0]       mode_i,
  output logic [PIX_W-1:0] color_c
);

  assign color_c = pack_argb(a_i, rgb_i.r, rgb_i.g, rgb_i.b, mode_i);

endmodule

// File: rtl/painterengine_gpu_rgb2argb.sv
// Unpacks 4 packed 24-bit RGB pixels per 3 input words into 32-bit ARGB beats.
// Optional colour keying is enabled by PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN.
module painterengine_gpu_rgb2argb
  import painterengine_gpu_color_pkg::*;
#(
  parameter logic [7:0] DEFAULT_ALPHA = 8'hFF
) (
  input  logic             i_wire_clock,
  input  logic             i_wire_resetn,
`ifdef PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN
  input  logic             i_wire_colorkey_enable,
  input  logic [RGB_W-1:0] i_wire_colorkey,
`endif
  input  logic [PIX_W-1:0] i_wire_rgb,
  input  logic             i_wire_valid,
  output logic             o_wire_ready,
  input  logic             i_wire_irgb_mode,
  input  logic [1:0]       i_wire_oargb_mode,
  input  logic             i_wire_alpha_override,
  input  logic [CH_W-1:0]  i_wire_alpha,
  input  logic             i_wire_flush,
  output logic [PIX_W-1:0] o_wire_color,
  output logic             o_wire_valid,
  input  logic             i_wire_ready
);

  logic [1:0]       rc_q, rc_d;
  logic [RGB_W-1:0] res_q, res_d;
  logic [PIX_W-1:0] color_q, color_d;
  logic             valid_q, valid_d;

  logic             slot_free_c;
  logic             accept_c;
  logic             emit_c;
  logic [RGB_W-1:0] px_c;
  rgb_t             rgb_c;
  logic [CH_W-1:0]  alpha_c;
  logic [PIX_W-1:0] packed_c;

  assign slot_free_c  = !valid_q || i_wire_ready;
  assign o_wire_ready = i_wire_resetn && slot_free_c && (rc_q != 2'd3) && !i_wire_flush;
  assign accept_c     = i_wire_valid && o_wire_ready;
  // The residue pixel drains on its own once three words have been consumed.
  assign emit_c       = accept_c || (slot_free_c && (rc_q == 2'd3) && !i_wire_flush);

  // Pixel bytes in stream order: px_c[7:0] is s0, px_c[23:16] is s2.
  always_comb begin
    px_c = res_q;
    case (rc_q)
      2'd0:    px_c = i_wire_rgb[23:0];
      2'd1:    px_c = {i_wire_rgb[15:0], res_q[7:0]};
      2'd2:    px_c = {i_wire_rgb[7:0], res_q[15:0]};
      default: px_c = res_q;
    endcase
  end

  always_comb begin
    rgb_c = '0;
    if (i_wire_irgb_mode == IRGB_RGB) begin
      rgb_c.r = px_c[7:0];
      rgb_c.g = px_c[15:8];
      rgb_c.b = px_c[23:16];
    end else begin
      rgb_c.b = px_c[7:0];
      rgb_c.g = px_c[15:8];
      rgb_c.r = px_c[23:16];
    end
  end

  always_comb begin
    alpha_c = i_wire_alpha_override ? i_wire_alpha : DEFAULT_ALPHA;
`ifdef PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN
    if (i_wire_colorkey_enable && (rgb_c == rgb_t'(i_wire_colorkey))) begin
      alpha_c = 8'h00;
    end
`endif
  end

  painterengine_gpu_argb_swizzle u_swizzle (
    .a_i     (alpha_c),
    .rgb_i   (rgb_c),
    .mode_i  (i_wire_oargb_mode),
    .color_c (packed_c)
  );

  // Residue/phase bookkeeping and output register next state.
  always_comb begin
    rc_d    = rc_q;
    res_d   = res_q;
    color_d = color_q;
    valid_d = valid_q;
    if (i_wire_flush) begin
      rc_d  = 2'd0;
      res_d = '0;
    end else if (accept_c) begin
      case (rc_q)
        2'd0: begin
          res_d = {16'h0000, i_wire_rgb[31:24]};
          rc_d  = 2'd1;
        end
        2'd1: begin
          res_d = {8'h00, i_wire_rgb[31:16]};
          rc_d  = 2'd2;
        end
        default: begin
          res_d = i_wire_rgb[31:8];
          rc_d  = 2'd3;
        end
      endcase
    end else if (emit_c) begin
      rc_d  = 2'd0;
      res_d = '0;
    end

    if (emit_c) begin
      color_d = packed_c;
      valid_d = 1'b1;
    end else if (i_wire_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      rc_q    <= 2'd0;
      res_q   <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rc_q    <= rc_d;
      res_q   <= res_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign o_wire_color = color_q;
  assign o_wire_valid = valid_q;

endmodule

// File: tb/tb_painterengine_gpu_rgb2argb.sv
// Directed bench for the RGB-to-ARGB unpacker with hand-computed pixels.
module tb_painterengine_gpu_rgb2argb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] rgb = '0;
  logic        vin = 1'b0;
  logic        o_ready;
  logic        irgb_mode = 1'b0;
  logic [1:0]  oargb_mode = 2'b00;
  logic        alpha_ovr = 1'b0;
  logic [7:0]  alpha = 8'h00;
  logic        flush = 1'b0;
  logic [31:0] o_color;
  logic        o_valid;
  logic        tb_ready = 1'b1;
`ifdef PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN
  logic        ck_en = 1'b0;
  logic [23:0] ck_key = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  bit  cnt_en = 1'b0;
  int  ready_low = 0;

  localparam logic [31:0] W1 = 32'h44332211;
  localparam logic [31:0] W2 = 32'h88776655;
  localparam logic [31:0] W3 = 32'hCCBBAA99;

  painterengine_gpu_rgb2argb #(.DEFAULT_ALPHA(8'hFF)) dut (
    .i_wire_clock          (clk),
    .i_wire_resetn         (rstn),
`ifdef PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN
    .i_wire_colorkey_enable(ck_en),
    .i_wire_colorkey       (ck_key),
`endif
    .i_wire_rgb            (rgb),
    .i_wire_valid          (vin),
    .o_wire_ready          (o_ready),
    .i_wire_irgb_mode      (irgb_mode),
    .i_wire_oargb_mode     (oargb_mode),
    .i_wire_alpha_override (alpha_ovr),
    .i_wire_alpha          (alpha),
    .i_wire_flush          (flush),
    .o_wire_color          (o_color),
    .o_wire_valid          (o_valid),
    .i_wire_ready          (tb_ready)
  );

  always #5 clk = ~clk;

  // Records every pixel that will be handed over at the coming edge.
  always @(negedge clk) begin
    if (rstn && o_valid && tb_ready) got.push_back(o_color);
    if (cnt_en && !o_ready) ready_low++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    bit ok = 1'b0;
    rgb = w;
    vin = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    vin = 1'b0;
    check("word_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare_pixels(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_px%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic run_group(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    got.delete();
    exp_q = '{e0, e1, e2, e3};
    send_word(W1);
    send_word(W2);
    send_word(W3);
    drain();
    compare_pixels(tag);
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_color", o_color, 32'h0);
    check("rst_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Default alpha, BGR stream, ARGB out; one ready bubble per group.
    cnt_en = 1'b1;
    run_group("basic", 32'hFF332211, 32'hFF665544, 32'hFF998877, 32'hFFCCBBAA);
    cnt_en = 1'b0;
    check("bubble_cycles", 32'(ready_low), 32'd1);

    irgb_mode = 1'b1; oargb_mode = 2'b01; alpha_ovr = 1'b1; alpha = 8'h80;
    run_group("rgb_abgr", 32'h80332211, 32'h80665544, 32'h80998877, 32'h80CCBBAA);
    irgb_mode = 1'b0; oargb_mode = 2'b10; alpha_ovr = 1'b0;
    run_group("bgr_rgba", 32'h332211FF, 32'h665544FF, 32'h998877FF, 32'hCCBBAAFF);
    oargb_mode = 2'b01; alpha_ovr = 1'b1; alpha = 8'h5A;
    run_group("bgr_abgr", 32'h5A112233, 32'h5A445566, 32'h5A778899, 32'h5AAABBCC);
    oargb_mode = 2'b00; alpha_ovr = 1'b0;

    // Downstream stall mid-group with the next word already offered.
    got.delete();
    send_word(W1);
    send_word(W2);
    tb_ready = 1'b0;
    rgb = W3;
    vin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_color", o_color, 32'hFF665544);
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_ready", 32'(o_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    tb_ready = 1'b1;
    send_word(W3);
    drain();
    exp_q = '{32'hFF332211, 32'hFF665544, 32'hFF998877, 32'hFFCCBBAA};
    compare_pixels("stall");

    // Flush discards the two residue bytes left after two words.
    got.delete();
    send_word(W1);
    send_word(W2);
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    send_word(W1);
    send_word(W2);
    send_word(W3);
    drain();
    exp_q = '{32'hFF332211, 32'hFF665544, 32'hFF332211, 32'hFF665544,
              32'hFF998877, 32'hFFCCBBAA};
    compare_pixels("flush");

    // Reset with a stalled pixel and residue pending.
    tb_ready = 1'b0;
    send_word(W1);
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_color", o_color, 32'h0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    tb_ready = 1'b1;
    got.delete();
    send_word(W2);
    drain();
    exp_q = '{32'hFF776655};
    compare_pixels("post_rst");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;

`ifdef PAINTERENGINE_GPU_RGB2ARGB_COLORKEY_EN
    ck_key = 24'h332211;
    ck_en = 1'b1;
    alpha_ovr = 1'b1;
    alpha = 8'hFF;
    run_group("colorkey", 32'h00332211, 32'hFF665544, 32'hFF998877, 32'hFFCCBBAA);
    ck_en = 1'b0;
    alpha_ovr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
